alu_ctrl_seq: RTL and testbench
===============================

# alu_ctrl_seq

Sequenced ALU controller for the 16-bit datapath. It decodes the instruction opcode into an ALU operation select and handles the new multi-cycle multiply: it holds the select, asserts a multiplier enable for a parametrised number of cycles and stalls issue meanwhile. Instructions arrive from decode on a valid/ready handshake. The block drives the ALU select mux and the multiplier enable, and tells writeback when the result is valid.

## Interface

Parameters:
- OPW, 4: opcode width, at least 4. Any opcode with a nonzero bit above bit 3 decodes as ADD.
- MUL_CYCLES, 4: multiply latency in cycles, at least 1.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, synchronous and active-low.
- in_valid, input, 1: opcode present.
- in_ready, output, 1: controller can accept an opcode this cycle.
- opcode, input, OPW: instruction opcode.
- flush, input, 1: synchronous pipeline flush.
- alu_sel, output, 3: registered ALU operation select.
- mul_en, output, 1: multiplier enable; high for every cycle of a multiply.
- out_valid, output, 1: one-cycle pulse; ALU result valid for writeback.

## Operation

Opcode to alu_sel decode:
- 0011 OR → 3
- 0100 AND → 2
- 1010 MUL → 1
- 0101 XOR → 4
- 0110 SUB → 5
- 0111 SLL → 6
- 1000 SRL → 7
- all other opcodes ADD → 0. Loads, stores and branches rely on this for address addition.

Handshake:
- An opcode is accepted when in_valid and in_ready are both high.
- in_ready is combinational from state: high in IDLE, and high in the last MUL_WAIT cycle.

FSM states: IDLE and MUL_WAIT. Down-counter cnt, width $clog2(MUL_CYCLES+1).
- IDLE, accept non-MUL: alu_sel loads the decode; out_valid = 1 for the next cycle; stay in IDLE.
- IDLE, accept MUL with MUL_CYCLES > 1: alu_sel = 1; cnt = MUL_CYCLES-1; go to MUL_WAIT.
- IDLE, accept MUL with MUL_CYCLES = 1: behaves as a single-cycle op, with mul_en high for that one output cycle.
- MUL_WAIT: mul_en = 1 and alu_sel is held. cnt decrements each cycle.
- MUL_WAIT with cnt = 0: out_valid = 1 and in_ready = 1. An opcode accepted here is handled exactly as in IDLE (back-to-back issue). With no accept, return to IDLE.

Flush and reset:
- flush forces IDLE and clears cnt. On the next cycle out_valid = 0 and mul_en = 0; alu_sel keeps its value.
- flush in the same cycle as an accept: flush wins and the opcode is discarded.
- rst_n low behaves like flush, and additionally clears alu_sel to 0.

Reset values: alu_sel = 0, out_valid = 0, mul_en = 0, state IDLE, so in_ready = 1.

## Timing

- Single-cycle op accepted at cycle N: alu_sel valid from N+1; out_valid high at N+1 only.
- MUL accepted at N: mul_en high N+1 … N+MUL_CYCLES; out_valid at N+MUL_CYCLES; in_ready low N+1 … N+MUL_CYCLES-1.
- Sustained throughput: one single-cycle op per cycle, or one MUL per MUL_CYCLES cycles.
- alu_sel, mul_en and out_valid are registered. in_ready has no combinational path from in_valid or opcode.
- rst_n deasserted mid-multiply: the block is in IDLE on the next edge and the multiply is abandoned with no out_valid.

## Structure

- Package alu_ctrl_pkg holds:
  - opcode localparams: OP_OR, OP_AND, OP_MUL, OP_XOR, OP_SUB, OP_SLL, OP_SRL;
  - 3-bit select constants SEL_ADD … SEL_SRL;
  - state enum {IDLE, MUL_WAIT}.
- The ALU and the multiplier import the same select constants.
- Sub-module alu_op_decode holds the purely combinational opcode → {sel, is_mul} decode. The top level holds the FSM, counter and registers.

## Test plan

- After reset: in_ready = 1, alu_sel = 0, out_valid = 0. Then accept 0011 → alu_sel = 3 and out_valid pulses one cycle.
- Accept 0100, 0101, 0110 on consecutive cycles → alu_sel = 2, 4, 5 on consecutive cycles, out_valid high three cycles. Opcodes 1111 and 0000 → alu_sel = 0.
- MUL_CYCLES = 4, accept 1010 at N:
  - mul_en high N+1..N+4;
  - in_ready low N+1..N+3;
  - out_valid only at N+4, with alu_sel = 1 throughout.
- MUL followed immediately by 0110 presented during MUL_WAIT → 0110 is accepted in the cnt = 0 cycle and alu_sel = 5 on the following cycle.
- Flush at N+2 of a MUL → IDLE at N+3, with mul_en = 0, no out_valid, in_ready = 1. Flush in the same cycle as accepting 0011 → no out_valid.
- MUL_CYCLES = 1 and OPW = 6: accept 001010 → one-cycle mul_en with out_valid. Accept 101010 → ADD (alu_sel = 0).

Source files
------------

// File: rtl/alu_ctrl_seq_pkg.sv
// Shared opcode encodings, ALU select codes and controller state type.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1010;

  localparam logic [2:0] SEL_ADD = 3'd0;
  localparam logic [2:0] SEL_MUL = 3'd1;
  localparam logic [2:0] SEL_AND = 3'd2;
  localparam logic [2:0] SEL_OR  = 3'd3;
  localparam logic [2:0] SEL_XOR = 3'd4;
  localparam logic [2:0] SEL_SUB = 3'd5;
  localparam logic [2:0] SEL_SLL = 3'd6;
  localparam logic [2:0] SEL_SRL = 3'd7;

  typedef enum logic {
    IDLE,
    MUL_WAIT
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode -> {ALU select, multiply flag} decode.
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OPW = 4
) (
  input  logic [OPW-1:0] i_opcode,
  output logic [2:0]     o_sel,
  output logic           o_is_mul
);

  logic w_hi;

  // Any set bit above bit 3 forces the ADD default.
  generate
    if (OPW > 4) begin : g_hi
      assign w_hi = |i_opcode[OPW-1:4];
    end else begin : g_nohi
      assign w_hi = 1'b0;
    end
  endgenerate

  // Map the low nibble onto the ALU select; unlisted opcodes add.
  always_comb begin
    o_sel    = SEL_ADD;
    o_is_mul = 1'b0;
    if (!w_hi) begin
      unique case (i_opcode[3:0])
        OP_OR:   o_sel = SEL_OR;
        OP_AND:  o_sel = SEL_AND;
        OP_XOR:  o_sel = SEL_XOR;
        OP_SUB:  o_sel = SEL_SUB;
        OP_SLL:  o_sel = SEL_SLL;
        OP_SRL:  o_sel = SEL_SRL;
        OP_MUL: begin
          o_sel    = SEL_MUL;
          o_is_mul = 1'b1;
        end
        default: o_sel = SEL_ADD;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Sequenced ALU controller: opcode decode, multi-cycle multiply hold/stall,
// registered select / multiplier enable / result-valid outputs.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OPW        = 4,
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] opcode,
  input  logic           flush,
  output logic [2:0]     alu_sel,
  output logic           mul_en,
  output logic           out_valid
);

  localparam int unsigned   CW       = $clog2(MUL_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic          MULTI    = (MUL_CYCLES > 1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_alu_sel, w_sel_nxt;
  logic          r_out_valid, w_ov_nxt;
  logic          r_mul_en, w_mul_nxt;
  logic          w_last, w_accept, w_dec_mul;
  logic [2:0]    w_dec_sel;

  alu_op_decode #(.OPW(OPW)) u_dec (
    .i_opcode (opcode),
    .o_sel    (w_dec_sel),
    .o_is_mul (w_dec_mul)
  );

  // Final multiply cycle doubles as an issue slot for back-to-back ops.
  assign w_last   = (r_state == MUL_WAIT) && (r_cnt == '0);
  assign in_ready = (r_state == IDLE) || w_last;
  assign w_accept = in_valid && in_ready && !flush;

  // State and countdown register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: flush dominates, then a new accept, then the multiply countdown.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (flush) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (w_accept) begin
      if (w_dec_mul && MULTI) begin
        w_state_nxt = MUL_WAIT;
        w_cnt_nxt   = CNT_LOAD;
      end else begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    end else if (r_state == MUL_WAIT) begin
      if (w_last) w_state_nxt = IDLE;
      else        w_cnt_nxt   = r_cnt - CW'(1);
    end
  end

  // Next output values; out_valid is timed so it lands in the cnt==0 cycle.
  always_comb begin
    w_sel_nxt = r_alu_sel;
    w_ov_nxt  = 1'b0;
    w_mul_nxt = 1'b0;
    if (flush) begin
      w_sel_nxt = r_alu_sel;
    end else if (w_accept) begin
      w_sel_nxt = w_dec_sel;
      if (w_dec_mul && MULTI) begin
        w_mul_nxt = 1'b1;
      end else begin
        w_ov_nxt  = 1'b1;
        w_mul_nxt = w_dec_mul;
      end
    end else if ((r_state == MUL_WAIT) && !w_last) begin
      w_mul_nxt = 1'b1;
      w_ov_nxt  = (r_cnt == CW'(1));
    end
  end

  // Output registers; reset additionally clears the select.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alu_sel   <= SEL_ADD;
      r_out_valid <= 1'b0;
      r_mul_en    <= 1'b0;
    end else begin
      r_alu_sel   <= w_sel_nxt;
      r_out_valid <= w_ov_nxt;
      r_mul_en    <= w_mul_nxt;
    end
  end

  assign alu_sel   = r_alu_sel;
  assign out_valid = r_out_valid;
  assign mul_en    = r_mul_en;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
`timescale 1ns/1ps
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid_a, flush_a, in_ready_a, mul_en_a, out_valid_a;
  logic [3:0] opcode_a;
  logic [2:0] alu_sel_a;
  logic       in_valid_b, flush_b, in_ready_b, mul_en_b, out_valid_b;
  logic [5:0] opcode_b;
  logic [2:0] alu_sel_b;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq #(.OPW(4), .MUL_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .opcode(opcode_a), .flush(flush_a), .alu_sel(alu_sel_a),
    .mul_en(mul_en_a), .out_valid(out_valid_a)
  );

  alu_ctrl_seq #(.OPW(6), .MUL_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .opcode(opcode_b), .flush(flush_b), .alu_sel(alu_sel_b),
    .mul_en(mul_en_b), .out_valid(out_valid_b)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel / out_valid / mul_en / in_ready of the 4-cycle instance
  task automatic chk_a(input string tag, input logic [2:0] s, input logic ov,
                       input logic me, input logic rdy);
    check({tag, ".sel"}, 8'(alu_sel_a), 8'(s));
    check({tag, ".ov"},  8'(out_valid_a), 8'(ov));
    check({tag, ".mul"}, 8'(mul_en_a), 8'(me));
    check({tag, ".rdy"}, 8'(in_ready_a), 8'(rdy));
  endtask

  task automatic chk_b(input string tag, input logic [2:0] s, input logic ov,
                       input logic me, input logic rdy);
    check({tag, ".sel"}, 8'(alu_sel_b), 8'(s));
    check({tag, ".ov"},  8'(out_valid_b), 8'(ov));
    check({tag, ".mul"}, 8'(mul_en_b), 8'(me));
    check({tag, ".rdy"}, 8'(in_ready_b), 8'(rdy));
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid_a = 1'b0; flush_a = 1'b0; opcode_a = 4'b0000;
    in_valid_b = 1'b0; flush_b = 1'b0; opcode_b = 6'b000000;
    tick(); tick();
    chk_a("reset_a", 3'd0, 1'b0, 1'b0, 1'b1);
    chk_b("reset_b", 3'd0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    tick();

    // OR, one-cycle out_valid pulse
    in_valid_a = 1'b1; opcode_a = 4'b0011;
    tick(); chk_a("or", 3'd3, 1'b1, 1'b0, 1'b1);
    in_valid_a = 1'b0;
    tick(); chk_a("or_after", 3'd3, 1'b0, 1'b0, 1'b1);

    // consecutive single-cycle ops and ADD defaults
    in_valid_a = 1'b1; opcode_a = 4'b0100;
    tick(); chk_a("and", 3'd2, 1'b1, 1'b0, 1'b1);
    opcode_a = 4'b0101;
    tick(); chk_a("xor", 3'd4, 1'b1, 1'b0, 1'b1);
    opcode_a = 4'b0110;
    tick(); chk_a("sub", 3'd5, 1'b1, 1'b0, 1'b1);
    opcode_a = 4'b0111;
    tick(); chk_a("sll", 3'd6, 1'b1, 1'b0, 1'b1);
    opcode_a = 4'b1000;
    tick(); chk_a("srl", 3'd7, 1'b1, 1'b0, 1'b1);
    opcode_a = 4'b1111;
    tick(); chk_a("op_f", 3'd0, 1'b1, 1'b0, 1'b1);
    opcode_a = 4'b0011;
    tick(); chk_a("or2", 3'd3, 1'b1, 1'b0, 1'b1);
    opcode_a = 4'b0000;
    tick(); chk_a("op_0", 3'd0, 1'b1, 1'b0, 1'b1);
    in_valid_a = 1'b0;
    tick(); chk_a("idle", 3'd0, 1'b0, 1'b0, 1'b1);

    // MUL, 4 cycles
    in_valid_a = 1'b1; opcode_a = 4'b1010;
    tick(); in_valid_a = 1'b0;
    chk_a("mul_n1", 3'd1, 1'b0, 1'b1, 1'b0);
    tick(); chk_a("mul_n2", 3'd1, 1'b0, 1'b1, 1'b0);
    tick(); chk_a("mul_n3", 3'd1, 1'b0, 1'b1, 1'b0);
    tick(); chk_a("mul_n4", 3'd1, 1'b1, 1'b1, 1'b1);
    tick(); chk_a("mul_n5", 3'd1, 1'b0, 1'b0, 1'b1);

    // MUL then SUB held until the cnt==0 cycle
    in_valid_a = 1'b1; opcode_a = 4'b1010;
    tick(); opcode_a = 4'b0110;
    chk_a("b2b_n1", 3'd1, 1'b0, 1'b1, 1'b0);
    tick(); chk_a("b2b_n2", 3'd1, 1'b0, 1'b1, 1'b0);
    tick(); chk_a("b2b_n3", 3'd1, 1'b0, 1'b1, 1'b0);
    tick(); chk_a("b2b_n4", 3'd1, 1'b1, 1'b1, 1'b1);
    tick(); in_valid_a = 1'b0;
    chk_a("b2b_n5", 3'd5, 1'b1, 1'b0, 1'b1);
    tick(); chk_a("b2b_n6", 3'd5, 1'b0, 1'b0, 1'b1);

    // flush at N+2 of a MUL
    in_valid_a = 1'b1; opcode_a = 4'b1010;
    tick(); in_valid_a = 1'b0;
    chk_a("fl_n1", 3'd1, 1'b0, 1'b1, 1'b0);
    tick(); flush_a = 1'b1;
    tick(); flush_a = 1'b0;
    chk_a("fl_n3", 3'd1, 1'b0, 1'b0, 1'b1);
    tick(); chk_a("fl_n4", 3'd1, 1'b0, 1'b0, 1'b1);
    tick(); chk_a("fl_n5", 3'd1, 1'b0, 1'b0, 1'b1);

    // flush coinciding with an accept discards the opcode
    in_valid_a = 1'b1; opcode_a = 4'b0011; flush_a = 1'b1;
    tick(); in_valid_a = 1'b0; flush_a = 1'b0;
    chk_a("fl_acc", 3'd1, 1'b0, 1'b0, 1'b1);

    // reset mid-multiply abandons it and clears the select
    in_valid_a = 1'b1; opcode_a = 4'b1010;
    tick(); in_valid_a = 1'b0;
    chk_a("rst_n1", 3'd1, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    chk_a("rst_mid", 3'd0, 1'b0, 1'b0, 1'b1);
    tick(); chk_a("rst_after", 3'd0, 1'b0, 1'b0, 1'b1);
    tick(); chk_a("rst_after2", 3'd0, 1'b0, 1'b0, 1'b1);

    // MUL_CYCLES=1, OPW=6
    in_valid_b = 1'b1; opcode_b = 6'b001010;
    tick(); chk_b("m1_mul", 3'd1, 1'b1, 1'b1, 1'b1);
    tick(); chk_b("m1_mul2", 3'd1, 1'b1, 1'b1, 1'b1);
    opcode_b = 6'b101010;
    tick(); chk_b("m1_hi", 3'd0, 1'b1, 1'b0, 1'b1);
    opcode_b = 6'b000011;
    tick(); chk_b("m1_or", 3'd3, 1'b1, 1'b0, 1'b1);
    opcode_b = 6'b010100;
    tick(); chk_b("m1_hi2", 3'd0, 1'b1, 1'b0, 1'b1);
    in_valid_b = 1'b0;
    tick(); chk_b("m1_idle", 3'd0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
